// File: rtl/cam_pixel_packer.sv
// Camera luma packer: synchronises an asynchronous 8-bit camera bus, packs bytes into 32-bit words and buffers them in a FIFO.
// Optional statistics counters are built only when CAM_PIXEL_PACKER_STATS_EN is defined.
module cam_pixel_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    input  logic [7:0]  cam_y_i,
    input  logic        cam_pclk_i,
    input  logic        cam_hsync_i,
    input  logic        cam_vsync_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic        ovf_o,
    output logic        partial_o,
    output logic [9:0]  line_cnt_o,
    output logic [15:0] word_cnt_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [SYNC_STAGES-1:0] pclk_sync_q;
    logic [SYNC_STAGES-1:0] hsync_sync_q;
    logic [SYNC_STAGES-1:0] vsync_sync_q;
    logic [7:0]             y_sync_q [SYNC_STAGES];
    logic                   pclk_prev_q;
    logic                   hsync_prev_q;
    logic                   vsync_prev_q;

    logic        pclk_s, hsync_s, vsync_s;
    logic [7:0]  y_s;
    logic        pclk_rise_s, hsync_rise_s, hsync_fall_s, vsync_rise_s, vsync_fall_s;

    logic [1:0]  state_q, state_d;
    logic        frame_start_s, frame_done_s;

    logic [1:0]  idx_q, idx_d;
    logic [23:0] pack_q, pack_d;
    logic        capture_s, line_end_s;
    logic        push_s, partial_set_s;
    logic [31:0] push_word_s;

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty_s, full_s, pop_s, push_ok_s, ovf_set_s;

    logic        ovf_q, partial_q, frame_start_q, frame_done_q;

    // Synchroniser chains plus previous-value flops for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_sync_q  <= '0;
            hsync_sync_q <= '0;
            vsync_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                y_sync_q[i] <= 8'd0;
            end
            pclk_prev_q  <= 1'b0;
            hsync_prev_q <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            pclk_sync_q[0]  <= cam_pclk_i;
            hsync_sync_q[0] <= cam_hsync_i;
            vsync_sync_q[0] <= cam_vsync_i;
            y_sync_q[0]     <= cam_y_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pclk_sync_q[i]  <= pclk_sync_q[i-1];
                hsync_sync_q[i] <= hsync_sync_q[i-1];
                vsync_sync_q[i] <= vsync_sync_q[i-1];
                y_sync_q[i]     <= y_sync_q[i-1];
            end
            pclk_prev_q  <= pclk_s;
            hsync_prev_q <= hsync_s;
            vsync_prev_q <= vsync_s;
        end
    end

    assign pclk_s       = pclk_sync_q[SYNC_STAGES-1];
    assign hsync_s      = hsync_sync_q[SYNC_STAGES-1];
    assign vsync_s      = vsync_sync_q[SYNC_STAGES-1];
    assign y_s          = y_sync_q[SYNC_STAGES-1];
    assign pclk_rise_s  = pclk_s & ~pclk_prev_q;
    assign hsync_rise_s = hsync_s & ~hsync_prev_q;
    assign hsync_fall_s = ~hsync_s & hsync_prev_q;
    assign vsync_rise_s = vsync_s & ~vsync_prev_q;
    assign vsync_fall_s = ~vsync_s & vsync_prev_q;

    // Frame FSM: a frame opens on vsync falling and closes on the next vsync rise.
    always_comb begin
        state_d       = state_q;
        frame_start_s = 1'b0;
        frame_done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (vsync_fall_s) begin
                    state_d       = ST_ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise_s) begin
                    frame_done_s = 1'b1;
                    state_d      = enable_i ? ST_SYNC : ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign capture_s  = pclk_rise_s & hsync_s & (state_q == ST_ACTIVE);
    assign line_end_s = hsync_fall_s & (state_q == ST_ACTIVE);

    // Byte packer; unfilled bytes of pack_q are always zero, so a flushed word is already padded.
    always_comb begin
        idx_d         = idx_q;
        pack_d        = pack_q;
        push_s        = 1'b0;
        push_word_s   = 32'd0;
        partial_set_s = 1'b0;
        if ((state_q != ST_ACTIVE) || hsync_rise_s) begin
            idx_d  = 2'd0;
            pack_d = 24'd0;
        end else if (capture_s) begin
            case (idx_q)
                2'd0: begin
                    pack_d[7:0] = y_s;
                    idx_d       = 2'd1;
                end
                2'd1: begin
                    pack_d[15:8] = y_s;
                    idx_d        = 2'd2;
                end
                2'd2: begin
                    pack_d[23:16] = y_s;
                    idx_d         = 2'd3;
                end
                2'd3: begin
                    push_s      = 1'b1;
                    push_word_s = {y_s, pack_q};
                    idx_d       = 2'd0;
                    pack_d      = 24'd0;
                end
                default: begin
                    idx_d  = 2'd0;
                    pack_d = 24'd0;
                end
            endcase
        end else if (line_end_s && (idx_q != 2'd0)) begin
            push_s        = 1'b1;
            push_word_s   = {8'd0, pack_q};
            partial_set_s = 1'b1;
            idx_d         = 2'd0;
            pack_d        = 24'd0;
        end else begin
            idx_d  = idx_q;
            pack_d = pack_q;
        end
    end

    // FSM state and packer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            pack_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pack_q  <= pack_d;
        end
    end

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign valid_o   = ~empty_s;
    assign pop_s     = valid_o & ready_i;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign ovf_set_s = push_s & full_s & ~pop_s;
    assign data_o    = empty_s ? 32'd0 : mem_q[rd_ptr_q[AW-1:0]];

    // Output FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_word_s;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Sticky flags (set beats clear) and registered frame pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q         <= 1'b0;
            partial_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_start_q <= frame_start_s;
            frame_done_q  <= frame_done_s;
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end else if (clear_i) begin
                ovf_q <= 1'b0;
            end
            if (partial_set_s) begin
                partial_q <= 1'b1;
            end else if (clear_i) begin
                partial_q <= 1'b0;
            end
        end
    end

    assign ovf_o         = ovf_q;
    assign partial_o     = partial_q;
    assign frame_start_o = frame_start_q;
    assign frame_done_o  = frame_done_q;

`ifdef CAM_PIXEL_PACKER_STATS_EN
    logic [9:0]  line_cnt_q;
    logic [15:0] word_cnt_q;

    // Saturating per-frame line and word counters.
    always_ff @(posedge clk_i) begin
        if (rst_i || frame_start_s) begin
            line_cnt_q <= 10'd0;
            word_cnt_q <= 16'd0;
        end else begin
            if (line_end_s && (line_cnt_q != 10'h3FF)) begin
                line_cnt_q <= line_cnt_q + 10'd1;
            end
            if (push_ok_s && (word_cnt_q != 16'hFFFF)) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

    assign line_cnt_o = line_cnt_q;
    assign word_cnt_o = word_cnt_q;
`else
    assign line_cnt_o = 10'd0;
    assign word_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer: camera lines are driven slowly (pclk = clk/8) and popped words are checked.
module tb_cam_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_i, enable_i, clear_i, ready_i;
    logic [7:0]  cam_y_i;
    logic        cam_pclk_i, cam_hsync_i, cam_vsync_i;
    logic [31:0] data_o;
    logic        valid_o, frame_start_o, frame_done_o, ovf_o, partial_o;
    logic [9:0]  line_cnt_o;
    logic [15:0] word_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;
    int fs_cnt   = 0;
    int fd_cnt   = 0;
    int hold_viol = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev = 32'd0;
    logic [31:0] popq [$];

`ifdef CAM_PIXEL_PACKER_STATS_EN
    localparam logic STATS_ON = 1'b1;
`else
    localparam logic STATS_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    cam_pixel_packer #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .cam_y_i(cam_y_i), .cam_pclk_i(cam_pclk_i), .cam_hsync_i(cam_hsync_i),
        .cam_vsync_i(cam_vsync_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .frame_start_o(frame_start_o), .frame_done_o(frame_done_o),
        .ovf_o(ovf_o), .partial_o(partial_o), .line_cnt_o(line_cnt_o),
        .word_cnt_o(word_cnt_o)
    );

    // Observe pulses, popped words and data stability under back-pressure.
    always @(posedge clk) begin
        if (frame_start_o) fs_cnt <= fs_cnt + 1;
        if (frame_done_o) fd_cnt <= fd_cnt + 1;
        if (valid_o && ready_i) popq.push_back(data_o);
        if (hold_prev && !rst_i && (data_o !== data_prev)) hold_viol <= hold_viol + 1;
        hold_prev <= valid_o && !ready_i && !rst_i;
        data_prev <= data_o;
    end

    function automatic logic [31:0] sx(input logic [31:0] v);
        return STATS_ON ? v : 32'd0;
    endfunction

    function automatic logic [31:0] pq(input int i);
        return (i < popq.size()) ? popq[i] : 32'hxxxxxxxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input logic [7:0] b);
        cam_y_i = b;
        cam_pclk_i = 1'b0;
        tick(4);
        cam_pclk_i = 1'b1;
        tick(4);
    endtask

    task automatic line(input logic [7:0] start, input int n);
        logic [7:0] b;
        cam_hsync_i = 1'b1;
        tick(4);
        b = start;
        for (int i = 0; i < n; i++) begin
            pix(b);
            b = b + 8'd1;
        end
        cam_pclk_i = 1'b0;
        tick(4);
        cam_hsync_i = 1'b0;
        tick(8);
    endtask

    task automatic vsync_pulse();
        cam_vsync_i = 1'b1;
        tick(6);
        cam_vsync_i = 1'b0;
        tick(6);
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
        cam_y_i = 8'd0; cam_pclk_i = 1'b0; cam_hsync_i = 1'b0; cam_vsync_i = 1'b0;
        tick(3);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
        chk("rst_partial", {31'd0, partial_o}, 32'd0);
        chk("rst_fs", {31'd0, frame_start_o}, 32'd0);
        chk("rst_fd", {31'd0, frame_done_o}, 32'd0);
        chk("rst_line", {22'd0, line_cnt_o}, 32'd0);
        chk("rst_word", {16'd0, word_cnt_o}, 32'd0);

        // Full 8-byte line.
        rst_i = 1'b0; enable_i = 1'b1;
        tick(2);
        vsync_pulse();
        line(8'h01, 8);
        chk("l1_fs", fs_cnt, 32'd1);
        chk("l1_n", popq.size(), 32'd2);
        chk("l1_w0", pq(0), 32'h04030201);
        chk("l1_w1", pq(1), 32'h08070605);
        chk("l1_line", {22'd0, line_cnt_o}, sx(32'd1));
        chk("l1_word", {16'd0, word_cnt_o}, sx(32'd2));
        chk("l1_partial", {31'd0, partial_o}, 32'd0);

        // 6-byte line gives a padded partial word.
        popq.delete();
        line(8'hA0, 6);
        chk("l2_w0", pq(0), 32'hA3A2A1A0);
        chk("l2_w1", pq(1), 32'h0000A5A4);
        chk("l2_partial", {31'd0, partial_o}, 32'd1);
        clear_pulse();
        chk("l2_clr", {31'd0, partial_o}, 32'd0);
        chk("l2_line", {22'd0, line_cnt_o}, sx(32'd2));
        chk("l2_word", {16'd0, word_cnt_o}, sx(32'd4));

        // Back-pressure: 5 words into a 4-deep FIFO.
        popq.delete();
        ready_i = 1'b0;
        line(8'h10, 20);
        chk("ovf_valid", {31'd0, valid_o}, 32'd1);
        chk("ovf_head", data_o, 32'h13121110);
        chk("ovf_flag", {31'd0, ovf_o}, 32'd1);
        chk("ovf_partial", {31'd0, partial_o}, 32'd0);
        chk("ovf_nopop", popq.size(), 32'd0);
        ready_i = 1'b1;
        tick(8);
        chk("ovf_n", popq.size(), 32'd4);
        chk("ovf_w0", pq(0), 32'h13121110);
        chk("ovf_w1", pq(1), 32'h17161514);
        chk("ovf_w2", pq(2), 32'h1B1A1918);
        chk("ovf_w3", pq(3), 32'h1F1E1D1C);
        chk("ovf_empty", {31'd0, valid_o}, 32'd0);
        chk("hold_stable", hold_viol, 32'd0);
        chk("ovf_word", {16'd0, word_cnt_o}, sx(32'd8));
        clear_pulse();
        chk("ovf_clr", {31'd0, ovf_o}, 32'd0);

        // Push onto full FIFO with a pop in the same cycle.
        popq.delete();
        ready_i = 1'b0;
        cam_hsync_i = 1'b1;
        tick(4);
        for (int i = 0; i < 19; i++) pix(8'h30 + 8'(i));
        cam_y_i = 8'h43;
        cam_pclk_i = 1'b0;
        tick(4);
        cam_pclk_i = 1'b1;
        tick(2);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
        tick(3);
        chk("fp_ovf", {31'd0, ovf_o}, 32'd0);
        chk("fp_valid", {31'd0, valid_o}, 32'd1);
        chk("fp_head", data_o, 32'h37363534);
        chk("fp_pop0", pq(0), 32'h33323130);
        cam_pclk_i = 1'b0;
        tick(4);
        cam_hsync_i = 1'b0;
        tick(8);
        ready_i = 1'b1;
        tick(10);
        chk("fp_n", popq.size(), 32'd5);
        chk("fp_w1", pq(1), 32'h37363534);
        chk("fp_w2", pq(2), 32'h3B3A3938);
        chk("fp_w3", pq(3), 32'h3F3E3D3C);
        chk("fp_w4", pq(4), 32'h43424140);
        chk("fp_line", {22'd0, line_cnt_o}, sx(32'd4));
        chk("fp_word", {16'd0, word_cnt_o}, sx(32'd13));

        // Reset in the middle of a line.
        popq.delete();
        cam_hsync_i = 1'b1;
        tick(4);
        pix(8'h50); pix(8'h51); pix(8'h52);
        rst_i = 1'b1;
        tick(1);
        chk("mr_valid", {31'd0, valid_o}, 32'd0);
        chk("mr_data", data_o, 32'd0);
        chk("mr_line", {22'd0, line_cnt_o}, 32'd0);
        chk("mr_word", {16'd0, word_cnt_o}, 32'd0);
        rst_i = 1'b0;
        pix(8'h53); pix(8'h54); pix(8'h55); pix(8'h56);
        cam_pclk_i = 1'b0;
        tick(4);
        cam_hsync_i = 1'b0;
        tick(8);
        chk("mr_nocap", popq.size(), 32'd0);
        chk("mr_fs", fs_cnt, 32'd1);
        vsync_pulse();
        line(8'h60, 4);
        chk("mr_fs2", fs_cnt, 32'd2);
        chk("mr_n", popq.size(), 32'd1);
        chk("mr_w0", pq(0), 32'h63626160);
        chk("mr_lc", {22'd0, line_cnt_o}, sx(32'd1));

        // Enable dropped mid-frame: frame completes, next frame ignored.
        popq.delete();
        enable_i = 1'b0;
        line(8'h70, 4);
        chk("en_n", popq.size(), 32'd1);
        chk("en_w0", pq(0), 32'h73727170);
        chk("en_line", {22'd0, line_cnt_o}, sx(32'd2));
        vsync_pulse();
        chk("en_fd", fd_cnt, 32'd1);
        chk("en_fs", fs_cnt, 32'd2);
        line(8'h80, 4);
        chk("en_nocap", popq.size(), 32'd1);
        chk("en_valid", {31'd0, valid_o}, 32'd0);
        chk("en_word", {16'd0, word_cnt_o}, sx(32'd2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pixel_packer.md
CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of 32-bit words in the output FIFO (power of two, 2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of flops synchronising each camera input into clk_i.
REQ-003 SHALL have port clk_i, input, 1, the single platform clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port enable_i, input, 1, the capture enable.
REQ-006 SHALL have port clear_i, input, 1, a one-cycle pulse that clears the sticky flags.
REQ-007 SHALL have port cam_y_i, input, 8, the camera luma byte; it is asynchronous to clk_i.
REQ-008 SHALL have ports cam_pclk_i, cam_hsync_i and cam_vsync_i, input, 1 each, the camera pixel clock, line-valid (active-high) and frame sync (active-high pulse in blanking); all are asynchronous to clk_i.
REQ-009 SHALL have port data_o, output, 32, the packed pixel word with the first pixel in [7:0].
REQ-010 SHALL have ports valid_o (output, 1) and ready_i (input, 1), the output handshake.
REQ-011 SHALL have ports frame_start_o and frame_done_o, output, 1 each, one-cycle pulses.
REQ-012 SHALL have ports ovf_o and partial_o, output, 1 each, sticky flags.
REQ-013 SHALL have ports line_cnt_o (output, 10) and word_cnt_o (output, 16), the statistics counters.

Function
REQ-014 SHALL pass cam_pclk_i, cam_hsync_i, cam_vsync_i and cam_y_i through SYNC_STAGES flops, plus one extra pclk flop for edge detection.
REQ-015 SHALL capture a pixel byte from the synchronised cam_y on the cycle a synchronised pclk rising edge is detected, while hsync is high and the state is ACTIVE.
REQ-016 SHALL support a pclk frequency of at most clk_i/4; behaviour above that rate is undefined.
REQ-017 SHALL use states IDLE, SYNC and ACTIVE: IDLE->SYNC when enable_i=1; SYNC->ACTIVE on a synchronised vsync falling edge, pulsing frame_start_o; ACTIVE->SYNC on a vsync rising edge when enable_i=1, otherwise ACTIVE->IDLE; in both cases frame_done_o pulses.
REQ-018 SHALL, when enable_i drops mid-frame, complete the current frame before entering IDLE; when enable_i drops in SYNC, return to IDLE the next cycle.
REQ-019 SHALL pack 4 captured bytes little-endian into one word and push it into the FIFO on the cycle the 4th byte is captured.
REQ-020 SHALL, on an hsync falling edge with 1-3 bytes pending, zero-pad the unfilled bytes, push the word, set partial_o and reset the byte index to 0.
REQ-021 SHALL reset the byte index on every hsync rising edge and every frame_start.
REQ-022 SHALL drive valid_o=1 whenever the FIFO is non-empty, with data_o showing the FIFO head combinationally.
REQ-023 SHALL pop the FIFO on a cycle with valid_o&ready_i, and SHALL hold data_o stable while valid_o=1 and ready_i=0.
REQ-024 SHALL accept a push onto a full FIFO only if a pop occurs in the same cycle.
REQ-025 SHALL otherwise drop the word that would be pushed onto a full FIFO and set ovf_o.
REQ-026 SHALL handle simultaneous push and pop on an empty FIFO as a normal push, so valid_o=1 on the next cycle.
REQ-027 SHALL give a latency of 1 clk_i cycle from the capture of the 4th byte to valid_o, when the FIFO is empty.
REQ-028 SHALL clear ovf_o and partial_o on clear_i; a set event in the same cycle as clear_i wins.
REQ-029 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty.

Reset
REQ-030 SHALL, on rst_i=1 at a clk_i edge, go to IDLE and clear the FIFO, byte index, sync flops and counters, with valid_o=0, data_o=0, all flags and pulses 0, and line_cnt_o=0, word_cnt_o=0.
REQ-031 SHALL, on rst_i mid-frame, discard all pending data and capture nothing until the next vsync falling edge after re-enable.

Configuration
REQ-032 SHALL compile the statistics counters only when CAM_PIXEL_PACKER_STATS_EN is defined.
REQ-033 SHALL, with CAM_PIXEL_PACKER_STATS_EN defined, increment line_cnt_o on each hsync falling edge in ACTIVE and word_cnt_o on each FIFO push; both clear at frame_start and saturate at all-ones.
REQ-034 SHALL, without CAM_PIXEL_PACKER_STATS_EN, tie line_cnt_o and word_cnt_o to constant 0 with no counter logic.

Verification
REQ-035 SHALL cover: vsync pulse, then an 8-byte line 0x01..0x08 with ready_i=1 -> words 0x04030201 and 0x08070605, frame_start_o once, line_cnt_o=1 and word_cnt_o=2 (stats on).
REQ-036 SHALL cover: a 6-byte line 0xA0..0xA5 -> words 0xA3A2A1A0 and 0x0000A5A4, partial_o=1; clear_i -> partial_o=0.
REQ-037 SHALL cover: ready_i=0, FIFO_DEPTH=4, 20 bytes -> 4 words held, 5th dropped, ovf_o=1; data_o stable at 0x(first word) until ready_i rises.
REQ-038 SHALL cover: full FIFO with ready_i=1 in the same cycle as a push -> no drop, ovf_o stays 0, occupancy stays 4.
REQ-039 SHALL cover: rst_i asserted after 3 bytes of a line -> valid_o=0 and counters 0 next cycle; after re-enable, no word until the next vsync falling edge.
REQ-040 SHALL cover: enable_i dropped mid-frame -> remaining lines still packed, frame_done_o pulses at the vsync rise, state IDLE, and no capture in the following frame.
